// File: rtl/reg_writeback.sv
// reg_writeback: register-file writeback arbiter with a small result buffer for the
// multicycle unit and a busy-register scoreboard.
//
// The main pipeline always wins the write port. Multicycle results wait in a FIFO and
// drain in cycles when the pipeline has no real writeback (pipe_rd == 0 counts as none).
// The scoreboard marks registers with an outstanding multicycle write. A bit is set on
// issue and cleared when the matching result leaves the FIFO.
//
// Ports
//   clk          clock, all state updates on rising edge
//   rst          asynchronous active-low reset
//   pipe_valid   pipeline writeback request (no backpressure)
//   pipe_rd      pipeline destination register
//   pipe_data    pipeline writeback data
//   mc_valid     multicycle result offered
//   mc_ready     buffer has room (count < DEPTH)
//   mc_rd        multicycle result destination register
//   mc_data      multicycle result data
//   issue_valid  multicycle operation issued
//   issue_rd     destination register of the issued operation
//   busy_mask    scoreboard, bit i = register i has a pending multicycle write
//   WE3          registered register-file write enable
//   A3           registered register-file write address
//   WD3          registered register-file write data
module reg_writeback #(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_valid,
    input  logic [4:0]  pipe_rd,
    input  logic [31:0] pipe_data,
    input  logic        mc_valid,
    output logic        mc_ready,
    input  logic [4:0]  mc_rd,
    input  logic [31:0] mc_data,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    output logic [31:0] busy_mask,
    output logic        WE3,
    output logic [4:0]  A3,
    output logic [31:0] WD3
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [4:0]      rd_mem   [DEPTH];
    logic [31:0]     data_mem [DEPTH];

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q,  count_d;

    logic [31:0]     busy_q,   busy_d;

    logic            we_q,     we_d;
    logic [4:0]      a3_q,     a3_d;
    logic [31:0]     wd_q,     wd_d;

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    logic        push;
    logic        pop;
    logic        pipe_req;
    logic [4:0]  head_rd;
    logic [31:0] head_data;

    assign mc_ready  = (count_q < CntW'(DEPTH));
    assign push      = mc_valid && mc_ready;
    assign pipe_req  = pipe_valid && (pipe_rd != 5'd0);
    // Pop decision uses the pre-push count, so an entry pushed this cycle is never
    // popped in the same cycle.
    assign pop       = !pipe_req && (count_q != '0);
    assign head_rd   = rd_mem[rd_ptr_q];
    assign head_data = data_mem[rd_ptr_q];

    // FIFO pointers and occupancy; pointers wrap naturally as DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    // Write-port selection: pipeline first, then FIFO head, else hold address/data.
    always_comb begin
        we_d = 1'b0;
        a3_d = a3_q;
        wd_d = wd_q;
        if (pipe_req) begin
            we_d = 1'b1;
            a3_d = pipe_rd;
            wd_d = pipe_data;
        end else if (pop) begin
            // A result aimed at x0 is drained but never written.
            we_d = (head_rd != 5'd0);
            a3_d = head_rd;
            wd_d = head_data;
        end
    end

    // Scoreboard: clear first, then set, so a same-cycle set/clear resolves to set.
    always_comb begin
        busy_d = busy_q;
        if (pop && (head_rd != 5'd0)) begin
            busy_d[head_rd] = 1'b0;
        end
        if (issue_valid && (issue_rd != 5'd0)) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            busy_q   <= '0;
            we_q     <= 1'b0;
            a3_q     <= 5'd0;
            wd_q     <= 32'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
            we_q     <= we_d;
            a3_q     <= a3_d;
            wd_q     <= wd_d;
        end
    end

    // Buffer storage needs no reset: entries are only read when count_q says they are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[wr_ptr_q]   <= mc_rd;
            data_mem[wr_ptr_q] <= mc_data;
        end
    end

    assign busy_mask = busy_q;
    assign WE3       = we_q;
    assign A3        = a3_q;
    assign WD3       = wd_q;

endmodule

// File: doc/reg_writeback.md
REG_WRITEBACK -- requirements
Module: reg_writeback

Interface
REQ-001 Parameter: DEPTH, 2, entries in the multicycle-result buffer; a power of two, at least 2.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 pipe_valid  input  1  main pipeline writeback request this cycle; no backpressure.
REQ-005 pipe_rd  input  5  destination register of the pipeline writeback.
REQ-006 pipe_data  input  32  pipeline writeback data.
REQ-007 mc_valid  input  1  multicycle-unit result offered.
REQ-008 mc_ready  output  1  buffer can accept a result; equals (count < DEPTH).
REQ-009 mc_rd  input  5  destination register of the multicycle result.
REQ-010 mc_data  input  32  multicycle result data.
REQ-011 issue_valid  input  1  a multicycle operation is issued.
REQ-012 issue_rd  input  5  destination register of the issued operation.
REQ-013 busy_mask  output  32  scoreboard; bit i set means register i has a pending multicycle write.
REQ-014 WE3  output  1  register-file write enable, registered.
REQ-015 A3  output  5  register-file write address, registered.
REQ-016 WD3  output  32  register-file write data, registered.

Function
REQ-017 An mc handshake SHALL occur in a cycle when mc_valid=1 and mc_ready=1; {mc_rd, mc_data} is pushed to the FIFO tail.
REQ-018 Write selection SHALL be evaluated each cycle from the current inputs and FIFO state, and the result registered onto WE3/A3/WD3 at the next edge.
REQ-019 Priority 1: if pipe_valid=1 and pipe_rd!=0, the next WE3=1, A3=pipe_rd, WD3=pipe_data; the FIFO is not popped.
REQ-020 Priority 2: otherwise, if count>0, the FIFO head is popped; next WE3=(head_rd!=0), A3=head_rd, WD3=head_data.
REQ-021 Otherwise the next WE3=0; A3 and WD3 hold their previous values.
REQ-022 pipe_valid=1 with pipe_rd=0 SHALL be treated as no request, so the FIFO may drain that cycle.
REQ-023 A pushed entry SHALL NOT be popped in the same cycle; minimum mc latency is handshake edge N, then WE3 visible after edge N+1.
REQ-024 A simultaneous push and pop SHALL leave count unchanged; push at full is impossible because mc_ready=0.
REQ-025 Read and write pointers SHALL wrap modulo DEPTH; count ranges from 0 to DEPTH.
REQ-026 FIFO ordering SHALL be strict first-in first-out.
REQ-027 Scoreboard set: issue_valid=1 and issue_rd!=0 sets busy_mask[issue_rd] at the next edge.
REQ-028 Scoreboard clear: a FIFO pop with head_rd!=0 clears busy_mask[head_rd] at the next edge.
REQ-029 A same-cycle set and clear of the same bit SHALL resolve to set.
REQ-030 Pipeline writes SHALL NOT modify busy_mask.
REQ-031 busy_mask[0] SHALL always be 0.

Reset
REQ-032 On rst=0, asynchronously and immediately: WE3=0, A3=0, WD3=0, busy_mask=0, FIFO pointers=0, count=0, mc_ready=1.
REQ-033 Reset asserted mid-operation SHALL discard all buffered results and pending scoreboard bits; no write is issued after reset releases until new input arrives.
REQ-034 While rst=0, inputs SHALL be ignored.

Verification
REQ-035 Reset: drive rst=0 mid-cycle with 2 entries buffered -> WE3=0 and busy_mask=0 immediately; mc_ready=1; after release, no WE3 pulse without new input.
REQ-036 Pipe only: pipe_valid=1, pipe_rd=5, pipe_data=0xDEADBEEF at edge N -> after edge N+1, WE3=1, A3=5, WD3=0xDEADBEEF; with pipe_rd=0 -> WE3=0.
REQ-037 MC path plus scoreboard: issue rd=7; later mc rd=7, data=0x12345678 with pipe idle -> busy_mask[7]=1 until the pop; WE3=1, A3=7 two edges after the handshake; busy_mask[7]=0 after the same edge.
REQ-038 Contention/full: pipe_valid=1 continuously with rd=3 while 3 mc results offered -> 2 accepted, mc_ready=0, only A3=3 written; drop pipe_valid -> FIFO entries written in order on consecutive cycles; mc_ready returns to 1 after the first pop.
REQ-039 Simultaneous set/clear: issue rd=9 in the same cycle the FIFO pops an rd=9 entry -> WE3=1, A3=9, and busy_mask[9] remains 1.
REQ-040 Wrap: stream 10 mc results (rd 1..10) with random pipe bubbles -> all 10 written exactly once, in order, with matching data.
